// File: rtl/oam_dma.sv
// OAM-style DMA bus initiator: copies LENGTH bytes from page {dma_src,00} to DST_BASE
// over a shared tristate bus, owning the wires only while bus_req and bus_gnt are both high.
module oam_dma #(
  parameter int unsigned LENGTH   = 160,
  parameter logic [15:0] DST_BASE = 16'hFE00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reg_we,
  input  logic [7:0]  reg_data,
  output logic [7:0]  dma_src,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] addr_ext,
  inout  wire  [7:0]  data_ext,
  output logic        mem_we,
  output logic        mem_re,
  output logic        dma_active,
  output logic        dma_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, READ = 2'd2, WRITE = 2'd3} state_t;

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  state_t      state_r;
  logic [7:0]  idx_r;
  logic [7:0]  latch_r;
  logic        own_s;
  logic        in_read_s;
  logic        in_write_s;

  assign in_read_s  = (state_r == READ);
  assign in_write_s = (state_r == WRITE);
  // Ownership follows the grant combinationally so a withdrawn grant frees the bus at once.
  assign own_s      = bus_gnt & (in_read_s | in_write_s);

  assign addr_ext = own_s ? (in_read_s ? {dma_src, idx_r} : DST_BASE + {8'h00, idx_r})
                          : 16'hzzzz;
  assign data_ext = (own_s & in_write_s) ? latch_r : 8'hzz;
  assign mem_re   = own_s ? in_read_s  : 1'bz;
  assign mem_we   = own_s ? in_write_s : 1'bz;

  // Transfer sequencer; a register write restarts from any state and overrides every transition.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      idx_r      <= 8'h00;
      latch_r    <= 8'h00;
      dma_src    <= 8'h00;
      bus_req    <= 1'b0;
      dma_active <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      if (reg_we) begin
        dma_src    <= reg_data;
        idx_r      <= 8'h00;
        state_r    <= REQ;
        bus_req    <= 1'b1;
        dma_active <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            bus_req    <= 1'b0;
            dma_active <= 1'b0;
          end
          REQ: begin
            if (bus_gnt) begin
              state_r <= READ;
            end
          end
          READ: begin
            if (bus_gnt) begin
              latch_r <= data_ext;
              state_r <= WRITE;
            end
          end
          WRITE: begin
            if (bus_gnt) begin
              if (idx_r == LAST_IDX) begin
                state_r    <= IDLE;
                bus_req    <= 1'b0;
                dma_active <= 1'b0;
                dma_done   <= 1'b1;
              end else begin
                idx_r   <= idx_r + 8'd1;
                state_r <= READ;
              end
            end
          end
          default: begin
            state_r    <= IDLE;
            bus_req    <= 1'b0;
            dma_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
